seq_enumerator: RTL and testbench



---
 rtl/seq_enumerator_pkg.sv | 19 +
 rtl/seq_odometer_step.sv | 40 ++++
 rtl/seq_enumerator.sv | 178 +++++++++++++++++
 tb/tb_seq_enumerator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_enumerator_pkg.sv
// Shared types and default sizing for the gate-sequence enumerator family.
// Optional incremental resend is enabled with the SEQ_ENUM_INCREMENTAL_EN macro.
package seq_enumerator_pkg;

  localparam int DEF_NUM_GATES   = 32;
  localparam int DEF_GATE_BITS   = 5;
  localparam int DEF_MAX_DEPTH   = 16;
  localparam int DEF_IDX_BITS    = 4;
  localparam int DEF_SEQ_ID_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ADV
  } state_t;

  typedef logic [DEF_GATE_BITS-1:0] gate_t;

endpackage

// File: rtl/seq_odometer_step.sv
// Combinational odometer increment over the low i_length gate digits.
// Reports the next digit vector, the highest changed digit k and a full-wrap flag.
module seq_odometer_step
  import seq_enumerator_pkg::*;
#(
  parameter int NUM_GATES = DEF_NUM_GATES,
  parameter int GATE_BITS = DEF_GATE_BITS,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int IDX_BITS  = DEF_IDX_BITS
) (
  input  logic [MAX_DEPTH-1:0][GATE_BITS-1:0] i_gates,
  input  logic [IDX_BITS:0]                   i_length,
  output logic [MAX_DEPTH-1:0][GATE_BITS-1:0] o_gates,
  output logic [IDX_BITS-1:0]                 o_k,
  output logic                                o_wrap
);

  localparam logic [GATE_BITS-1:0] LP_MAX_GATE = GATE_BITS'(NUM_GATES - 1);

  always_comb begin
    logic w_carry;
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    o_gates = i_gates;
    o_k     = '0;
    w_carry = 1'b1;
    for (int j = 0; j < MAX_DEPTH; j++) begin
      if (w_carry && ((IDX_BITS+1)'(j) < i_length)) begin
        if (i_gates[j] == LP_MAX_GATE) begin
          o_gates[j] = '0;
        end else begin
          o_gates[j] = i_gates[j] + 1'b1;
          o_k        = IDX_BITS'(j);
          w_carry    = 1'b0;
        end
      end
    end
    o_wrap = w_carry;
  end

endmodule

// File: rtl/seq_enumerator.sv
// Enumerates all gate sequences up to a configured length and streams each one, highest index first.
// Define SEQ_ENUM_INCREMENTAL_EN to resend only the changed suffix after an advance.
module seq_enumerator
  import seq_enumerator_pkg::*;
#(
  parameter int NUM_GATES   = DEF_NUM_GATES,
  parameter int GATE_BITS   = DEF_GATE_BITS,
  parameter int MAX_DEPTH   = DEF_MAX_DEPTH,
  parameter int IDX_BITS    = DEF_IDX_BITS,
  parameter int SEQ_ID_BITS = DEF_SEQ_ID_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDX_BITS:0]      cfg_length,
  input  logic                   grow_mode,
  input  logic                   start,
  input  logic                   advance,
  input  logic                   replay,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_BITS:0]      cur_length,
  output logic [SEQ_ID_BITS-1:0] seq_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_BITS-1:0]    out_index,
  output logic [GATE_BITS-1:0]   out_gate,
  output logic                   out_first,
  output logic                   out_last
);

  localparam logic [IDX_BITS:0] LP_MAX_LEN = (IDX_BITS+1)'(MAX_DEPTH);
  localparam logic [IDX_BITS:0] LP_ONE     = (IDX_BITS+1)'(1);

  state_t                              r_state;
  logic [IDX_BITS:0]                   r_eff_len;
  logic [IDX_BITS:0]                   r_cur_length;
  logic                                r_grow;
  logic                                r_done;
  logic [SEQ_ID_BITS-1:0]              r_seq_id;
  logic                                r_out_valid;
  logic [IDX_BITS-1:0]                 r_out_index;
  logic [GATE_BITS-1:0]                r_out_gate;
  logic [MAX_DEPTH-1:0][GATE_BITS-1:0] r_gates;

  logic [IDX_BITS:0]                   w_eff_len;
  logic [IDX_BITS:0]                   w_first_len;
  logic [IDX_BITS-1:0]                 w_first_idx;
  logic [IDX_BITS:0]                   w_len_m1;
  logic [IDX_BITS-1:0]                 w_top_idx;
  logic [IDX_BITS-1:0]                 w_prev_idx;
  logic [IDX_BITS-1:0]                 w_resend_idx;
  logic [MAX_DEPTH-1:0][GATE_BITS-1:0] w_next_gates;
  logic [IDX_BITS-1:0]                 w_k;
  logic                                w_wrap;
  logic                                w_can_grow;

  assign w_eff_len   = (cfg_length > LP_MAX_LEN) ? LP_MAX_LEN : cfg_length;
  assign w_first_len = grow_mode ? LP_ONE : w_eff_len;
  assign w_first_idx = IDX_BITS'(w_first_len - LP_ONE);
  assign w_len_m1    = r_cur_length - LP_ONE;
  assign w_top_idx   = w_len_m1[IDX_BITS-1:0];
  assign w_prev_idx  = r_out_index - IDX_BITS'(1);
  assign w_can_grow  = r_grow && (r_cur_length < r_eff_len);

  seq_odometer_step #(
    .NUM_GATES (NUM_GATES),
    .GATE_BITS (GATE_BITS),
    .MAX_DEPTH (MAX_DEPTH),
    .IDX_BITS  (IDX_BITS)
  ) u_step (
    .i_gates  (r_gates),
    .i_length (r_cur_length),
    .o_gates  (w_next_gates),
    .o_k      (w_k),
    .o_wrap   (w_wrap)
  );

`ifdef SEQ_ENUM_INCREMENTAL_EN
  // Digits above k are unchanged, so the multiplier keeps its cached prefix product.
  assign w_resend_idx = w_k;
`else
  logic w_unused_k;
  assign w_unused_k   = ^w_k;
  assign w_resend_idx = w_top_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_eff_len    <= '0;
      r_cur_length <= '0;
      r_grow       <= 1'b0;
      r_done       <= 1'b0;
      r_seq_id     <= '0;
      r_out_valid  <= 1'b0;
      r_out_index  <= '0;
      r_out_gate   <= '0;
      // NOTE: the digit array is a small flop bank, not a RAM, so clearing it on reset is cheap and keeps out_gate defined.
      r_gates      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_eff_len <= w_eff_len;
            r_grow    <= grow_mode;
            if (w_eff_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_done       <= 1'b0;
              r_cur_length <= w_first_len;
              r_gates      <= '0;
              r_seq_id     <= '0;
              r_out_index  <= w_first_idx;
              r_out_gate   <= '0;
              r_out_valid  <= 1'b1;
              r_state      <= SEND;
            end
          end
        end

        SEND: begin
          if (out_ready) begin
            if (r_out_index == '0) begin
              r_out_valid <= 1'b0;
              r_state     <= WAIT_ADV;
            end else begin
              r_out_index <= w_prev_idx;
              r_out_gate  <= r_gates[w_prev_idx];
            end
          end
        end

        WAIT_ADV: begin
          if (replay) begin
            r_out_index <= w_top_idx;
            r_out_gate  <= r_gates[w_top_idx];
            r_out_valid <= 1'b1;
            r_state     <= SEND;
          end else if (advance) begin
            if (!w_wrap) begin
              r_gates     <= w_next_gates;
              r_seq_id    <= r_seq_id + 1'b1;
              r_out_index <= w_resend_idx;
              r_out_gate  <= w_next_gates[w_resend_idx];
              r_out_valid <= 1'b1;
              r_state     <= SEND;
            end else if (w_can_grow) begin
              // The new top index equals the old length.
              r_cur_length <= r_cur_length + LP_ONE;
              r_gates      <= '0;
              r_seq_id     <= r_seq_id + 1'b1;
              r_out_index  <= r_cur_length[IDX_BITS-1:0];
              r_out_gate   <= '0;
              r_out_valid  <= 1'b1;
              r_state      <= SEND;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign cur_length = r_cur_length;
  assign seq_id     = r_seq_id;
  assign out_valid  = r_out_valid;
  assign out_index  = r_out_index;
  assign out_gate   = r_out_gate;
  assign out_first  = r_out_valid && ((IDX_BITS+1)'(r_out_index) == w_len_m1);
  assign out_last   = r_out_valid && (r_out_index == '0);

endmodule

// File: tb/tb_seq_enumerator.sv
// Self-checking bench for seq_enumerator (4 gates, depth 3): table-driven full enumerations
// plus hand-written replay, reset and incremental-resend sequences, checked by a beat scoreboard.
module tb_seq_enumerator;

  localparam int NG = 4;
  localparam int GB = 2;
  localparam int MD = 3;
  localparam int IB = 2;
  localparam int SB = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [IB:0]   cfg_length;
  logic          grow_mode, start, advance, replay, out_ready;
  logic          busy, done, out_valid, out_first, out_last;
  logic [IB:0]   cur_length;
  logic [SB-1:0] seq_id;
  logic [IB-1:0] out_index;
  logic [GB-1:0] out_gate;

  always #5 clk = ~clk;

  seq_enumerator #(
    .NUM_GATES(NG), .GATE_BITS(GB), .MAX_DEPTH(MD), .IDX_BITS(IB), .SEQ_ID_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .cfg_length(cfg_length), .grow_mode(grow_mode),
    .start(start), .advance(advance), .replay(replay), .busy(busy), .done(done),
    .cur_length(cur_length), .seq_id(seq_id), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_gate(out_gate), .out_first(out_first), .out_last(out_last)
  );

  typedef struct packed {
    logic [IB-1:0] idx;
    logic [GB-1:0] gate;
    logic          first;
    logic          last;
    logic [SB-1:0] id;
    logic [IB:0]   len;
  } beat_t;

  typedef struct {
    int cfg;
    bit grow;
    bit bp;
    int exp_beats;
    int exp_last_id;
  } row_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_xfer = 0;
  bit    mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_gates[MD];
  int m_len, m_eff, m_id;
  bit m_grow;

  task automatic m_push(input int from);
    for (int i = from; i >= 0; i--) begin
      beat_t b;
      b.idx   = IB'(i);
      b.gate  = GB'(m_gates[i]);
      b.first = (i == m_len - 1);
      b.last  = (i == 0);
      b.id    = SB'(m_id);
      b.len   = (IB+1)'(m_len);
      exp_q.push_back(b);
    end
  endtask

  task automatic m_clear();
    for (int j = 0; j < MD; j++) m_gates[j] = 0;
  endtask

  task automatic m_start(input int cfg, input bit grow);
    m_eff  = (cfg > MD) ? MD : cfg;
    m_grow = grow;
    if (m_eff != 0) begin
      m_len = grow ? 1 : m_eff;
      m_id  = 0;
      m_clear();
      m_push(m_len - 1);
    end
  endtask

  task automatic m_advance(output bit fin);
    int k;
    k   = -1;
    fin = 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (k < 0 && m_gates[j] != NG - 1) k = j;
    end
    if (k >= 0) begin
      m_gates[k]++;
      for (int j = 0; j < k; j++) m_gates[j] = 0;
      m_id++;
`ifdef SEQ_ENUM_INCREMENTAL_EN
      m_push(k);
`else
      m_push(m_len - 1);
`endif
    end else if (m_grow && m_len < m_eff) begin
      m_len++;
      m_clear();
      m_id++;
      m_push(m_len - 1);
    end else begin
      fin = 1'b1;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: idx=%0d gate=%0d id=%0d with nothing expected", out_index, out_gate, seq_id);
      end else begin
        check(out_ready ? "beat" : "beat_held",
              {out_index, out_gate, out_first, out_last, seq_id, cur_length}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (out_valid && out_ready) n_xfer++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      tick();
      c++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_advance();
    bit fin;
    advance = 1'b1;
    m_advance(fin);
    tick();
    advance = 1'b0;
  endtask

  row_t rows[4];

  initial begin
    int x0, cycles;
    bit fin;

    rows[0] = '{cfg: 2, grow: 0, bp: 0, exp_beats: 32, exp_last_id: 15};
    rows[1] = '{cfg: 2, grow: 0, bp: 1, exp_beats: 32, exp_last_id: 15};
    rows[2] = '{cfg: 2, grow: 1, bp: 0, exp_beats: 36, exp_last_id: 19};
    rows[3] = '{cfg: 5, grow: 0, bp: 0, exp_beats: 192, exp_last_id: 63};
`ifdef SEQ_ENUM_INCREMENTAL_EN
    rows[0].exp_beats = 20;
    rows[1].exp_beats = 20;
    rows[2].exp_beats = 24;
    rows[3].exp_beats = 84;
`endif

    reset = 1'b1; cfg_length = '0; grow_mode = 1'b0; start = 1'b0;
    advance = 1'b0; replay = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("reset_state", {busy, done, cur_length, seq_id, out_valid, out_index, out_gate, out_first, out_last}, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // zero length: done next cycle, no beats
    cfg_length = 0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_len_done", {done, busy, out_valid}, 3'b100);
    tick();
    check("zero_len_idle", {done, busy, out_valid}, 3'b100);

    // table-driven full enumerations with advance held high
    for (int r = 0; r < 4; r++) begin
      cfg_length = (IB+1)'(rows[r].cfg);
      grow_mode  = rows[r].grow;
      advance    = 1'b1;
      out_ready  = 1'b1;
      start      = 1'b1;
      m_start(rows[r].cfg, rows[r].grow);
      do m_advance(fin); while (!fin);
      x0 = n_xfer;
      tick();
      start = 1'b0;
      check("start_busy_valid", {busy, done, out_valid}, 3'b101);
      cycles = 0;
      while (!done && cycles < 3000) begin
        tick();
        out_ready = rows[r].bp ? ~out_ready : 1'b1;
        cycles++;
      end
      check("row_done", done, 1'b1);
      check("row_beats", n_xfer - x0, rows[r].exp_beats);
      check("row_last_id", seq_id, rows[r].exp_last_id);
      check("row_idle", {busy, out_valid}, 2'b00);
      check("row_queue_empty", exp_q.size(), 0);
      exp_q.delete();
      out_ready = 1'b1;
      tick(); tick();
      check("done_held", done, 1'b1);
    end

    // replay has priority over a simultaneous advance
    advance = 1'b0; cfg_length = 2; grow_mode = 1'b0; start = 1'b1;
    m_start(2, 1'b0);
    tick();
    start = 1'b0;
    wait_drain("drain_first");
    for (int s = 0; s < 6; s++) begin
      pulse_advance();
      wait_drain("drain_step");
    end
    check("at_seq_1_2", {seq_id, busy, out_valid}, {32'd6, 1'b1, 1'b0});
    replay = 1'b1; advance = 1'b1;
    m_push(m_len - 1);
    tick();
    replay = 1'b0; advance = 1'b0;
    check("replay_restart", {out_valid, out_index, out_gate, out_first}, {1'b1, 2'd1, 2'd1, 1'b1});
    wait_drain("drain_replay");
    check("replay_keeps_id", seq_id, 6);
    pulse_advance();
    wait_drain("drain_after_replay");
    check("after_replay_id", seq_id, 7);

    // reset in the middle of a send aborts the stream
    reset = 1'b1;
    tick();
    check("reset_mid_send", {busy, done, out_valid, out_index, out_gate, seq_id, cur_length}, 0);
    exp_q.delete();
    tick();
    check("reset_no_beat", out_valid, 1'b0);
    reset = 1'b0;
    cfg_length = 3; start = 1'b1;
    m_start(3, 1'b0);
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("reset_after_start", {busy, out_valid}, 2'b00);
    exp_q.delete();
    reset = 1'b0;
    tick();

`ifdef SEQ_ENUM_INCREMENTAL_EN
    // incremental resend only transmits the changed suffix
    cfg_length = 3; start = 1'b1;
    m_start(3, 1'b0);
    tick();
    start = 1'b0;
    wait_drain("incr_drain0");
    pulse_advance();
    check("incr_low_only", {out_valid, out_index, out_gate, out_first}, {1'b1, 2'd0, 2'd1, 1'b0});
    wait_drain("incr_drain1");
    pulse_advance();
    wait_drain("incr_drain2");
    pulse_advance();
    wait_drain("incr_drain3");
    pulse_advance();
    check("incr_carry", {out_valid, out_index, out_gate, out_first}, {1'b1, 2'd1, 2'd1, 1'b0});
    wait_drain("incr_drain4");
    check("incr_id", seq_id, 4);
`endif

    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
